// File: rtl/cache_port_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the cache port.
//   req/req_addr/req_data : requester side, packed 32-bit slice per requester
//   gnt/ack/rdata/err/busy: arbiter status back to the requesters
//   cache_address/cache_data/cache_response/cache_out : single cache port
// Modport slave is the arbiter's view; master is the environment's view
// (requesters plus cache).
interface cache_port_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    ack;
  logic [31:0]           rdata;
  logic                  err;
  logic                  busy;
  logic [31:0]           cache_address;
  logic [31:0]           cache_data;
  logic                  cache_response;
  logic [31:0]           cache_out;

  modport slave (
    input  req, req_addr, req_data, cache_response, cache_out,
    output gnt, ack, rdata, err, busy, cache_address, cache_data
  );

  modport master (
    output req, req_addr, req_data, cache_response, cache_out,
    input  gnt, ack, rdata, err, busy, cache_address, cache_data
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing the single port of a direct-mapped cache among
// NUM_REQ requesters. One access at a time is held on the cache port until the
// cache response drops; a repeated {address,data} is answered from local
// mirror registers without touching the cache; a watchdog aborts slow accesses.
// Ports:
//   clk   : system clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : cache_port_arbiter_if.slave (requesters + cache port), all
//           outputs registered
//
// state | meaning
// IDLE  | no access; arbitrate among pending requests
// ISSUE | new address/data on the cache port, cache sees the change
// WAIT  | waiting for cache_response to drop, watchdog running
// DONE  | ack pulse to the granted requester, err if timed out
module cache_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int RAM_AW  = 12,
  parameter int TIMEOUT = 255
) (
  input logic                clk,
  input logic                rst_n,
  cache_port_arbiter_if.slave bus
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q;
  logic [IDXW-1:0]     rr_ptr_q;
  logic [IDXW-1:0]     idx_q;
  logic [RAM_AW-1:0]   addr_lo_q;
  logic [31:0]         data_q;
  logic [WDW-1:0]      wd_cnt_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic                busy_q;
  logic [31:0]         cache_address_q;
  logic [31:0]         cache_data_q;
  logic [RAM_AW-1:0]   last_addr_q;
  logic [31:0]         last_data_q;
  logic [31:0]         last_rdata_q;

  logic [31:0]         addr_arr [NUM_REQ];
  logic [31:0]         data_arr [NUM_REQ];

  logic                pick_vld_d;
  logic [IDXW-1:0]     pick_idx_d;
  logic [IDXW-1:0]     cand_d;
  logic [31:0]         pick_addr_d;
  logic [31:0]         pick_data_d;
  logic                repeat_hit_d;
  logic [NUM_REQ-1:0]  pick_onehot_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = bus.req_addr[32*i +: 32];
    assign data_arr[i] = bus.req_data[32*i +: 32];
  end

  // Walk from the farthest candidate to the nearest so the first set bit
  // after rr_ptr overwrites all others.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    cand_d     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_d = IDXW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (bus.req[cand_d]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = cand_d;
      end
    end
  end

  assign pick_addr_d   = addr_arr[pick_idx_d];
  assign pick_data_d   = data_arr[pick_idx_d];
  assign pick_onehot_d = NUM_REQ'(1) << pick_idx_d;
  // The cache only compares the low RAM_AW address bits, so aliases repeat.
  assign repeat_hit_d  = (pick_addr_d[RAM_AW-1:0] == last_addr_q) &&
                         (pick_data_d == last_data_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rr_ptr_q        <= IDXW'(NUM_REQ - 1);
      idx_q           <= '0;
      addr_lo_q       <= '0;
      data_q          <= '0;
      wd_cnt_q        <= '0;
      gnt_q           <= '0;
      ack_q           <= '0;
      rdata_q         <= '0;
      err_q           <= 1'b0;
      busy_q          <= 1'b0;
      cache_address_q <= '0;
      cache_data_q    <= '0;
      last_addr_q     <= '0;
      last_data_q     <= '0;
      last_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            idx_q     <= pick_idx_d;
            addr_lo_q <= pick_addr_d[RAM_AW-1:0];
            data_q    <= pick_data_d;
            gnt_q     <= pick_onehot_d;
            busy_q    <= 1'b1;
            if (repeat_hit_d) begin
              rdata_q <= last_rdata_q;
              ack_q   <= pick_onehot_d;
              state_q <= DONE;
            end else begin
              cache_address_q <= pick_addr_d;
              cache_data_q    <= pick_data_d;
              state_q         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wd_cnt_q <= '0;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (!bus.cache_response) begin
            rdata_q      <= bus.cache_out;
            last_rdata_q <= bus.cache_out;
            last_addr_q  <= addr_lo_q;
            last_data_q  <= data_q;
            ack_q        <= gnt_q;
            state_q      <= DONE;
          end else if (wd_cnt_q == WDW'(TIMEOUT - 1)) begin
            // The cache already latched this address/data, so the mirror
            // must follow even though the access is aborted.
            err_q        <= 1'b1;
            rdata_q      <= '0;
            last_rdata_q <= '0;
            last_addr_q  <= addr_lo_q;
            last_data_q  <= data_q;
            ack_q        <= gnt_q;
            state_q      <= DONE;
          end else begin
            wd_cnt_q <= wd_cnt_q + WDW'(1);
          end
        end
        DONE: begin
          rr_ptr_q <= idx_q;
          gnt_q    <= '0;
          ack_q    <= '0;
          err_q    <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.ack           = ack_q;
  assign bus.rdata         = rdata_q;
  assign bus.err           = err_q;
  assign bus.busy          = busy_q;
  assign bus.cache_address = cache_address_q;
  assign bus.cache_data    = cache_data_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
module tb_cache_port_arbiter;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_port_arbiter_if #(.NUM_REQ(NR)) bus();

  cache_port_arbiter #(.NUM_REQ(NR), .RAM_AW(12), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  int          lat;
  logic [3:0]  ack_s, gnt_s;
  logic [31:0] rdata_s;
  logic        err_s, busy_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [31:0] addr, input logic [31:0] data);
    bus.req_addr[32*idx +: 32] = addr;
    bus.req_data[32*idx +: 32] = data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.cache_response = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Drives rq, holds cache_response high for hold_busy WAIT cycles, and
  // reports the number of edges from the sampling edge to the ack.
  task automatic access(input logic [3:0] rq, input int hold_busy, input bit drop);
    bus.req = rq;
    bus.cache_response = (hold_busy > 0);
    lat = -1; ack_s = '0; gnt_s = '0; rdata_s = '0; err_s = 1'b0; busy_s = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (n == 1) begin
        gnt_s  = bus.gnt;
        busy_s = bus.busy;
      end
      if (bus.ack != '0) begin
        lat = n; ack_s = bus.ack; rdata_s = bus.rdata; err_s = bus.err;
        break;
      end
      if (n == 2 + hold_busy) bus.cache_response = 1'b0;
    end
    if (drop) bus.req = '0;
  endtask

  task automatic post_idle(input string tag);
    step();
    check({tag, "_ack_clear"}, 32'(bus.ack), 32'h0);
    check({tag, "_gnt_clear"}, 32'(bus.gnt), 32'h0);
    check({tag, "_busy_low"},  32'(bus.busy), 32'h0);
    check({tag, "_err_clear"}, 32'(bus.err), 32'h0);
  endtask

  logic [3:0] seq [5];
  int k, busy_low, multi_gnt, pulses;
  logic [3:0] ack_seen;

  initial begin
    bus.req = '0; bus.req_addr = '0; bus.req_data = '0;
    bus.cache_response = 1'b0; bus.cache_out = '0;
    #3;
    check("rst_gnt",   32'(bus.gnt), 32'h0);
    check("rst_ack",   32'(bus.ack), 32'h0);
    check("rst_err",   32'(bus.err), 32'h0);
    check("rst_busy",  32'(bus.busy), 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_caddr", bus.cache_address, 32'h0);
    check("rst_cdata", bus.cache_data, 32'h0);
    do_reset();

    // T1: miss with 4 busy cycles
    set_req(0, 32'h10, 32'h5);
    bus.cache_out = 32'hAB;
    access(4'b0001, 4, 1'b1);
    check("t1_gnt",   32'(gnt_s), 32'h1);
    check("t1_busy",  32'(busy_s), 32'h1);
    check("t1_lat",   32'(lat), 32'd7);
    check("t1_ack",   32'(ack_s), 32'h1);
    check("t1_rdata", rdata_s, 32'hAB);
    check("t1_err",   32'(err_s), 32'h0);
    check("t1_caddr", bus.cache_address, 32'h10);
    check("t1_cdata", bus.cache_data, 32'h5);
    post_idle("t1");

    // T3: aliased repeat answered locally
    set_req(0, 32'h1010, 32'h5);
    bus.cache_out = 32'hCD;
    access(4'b0001, 0, 1'b1);
    check("t3_lat",   32'(lat), 32'd1);
    check("t3_ack",   32'(ack_s), 32'h1);
    check("t3_rdata", rdata_s, 32'hAB);
    check("t3_caddr", bus.cache_address, 32'h10);
    post_idle("t3");

    // T4: watchdog timeout, then repeat of the aborted access
    set_req(1, 32'h200, 32'h77);
    bus.cache_out = 32'hEE;
    access(4'b0010, 1000, 1'b1);
    check("t4_lat",   32'(lat), 32'd10);
    check("t4_ack",   32'(ack_s), 32'h2);
    check("t4_err",   32'(err_s), 32'h1);
    check("t4_rdata", rdata_s, 32'h0);
    post_idle("t4");
    access(4'b0010, 0, 1'b1);
    check("t4r_lat",   32'(lat), 32'd1);
    check("t4r_rdata", rdata_s, 32'h0);
    check("t4r_err",   32'(err_s), 32'h0);
    post_idle("t4r");

    // T2: all four requesting continuously
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 32'h100 + 32'(4 * i), 32'(i + 1));
    bus.cache_out = 32'h55;
    bus.req = 4'b1111;
    k = 0; busy_low = 0; multi_gnt = 0;
    for (int n = 0; n < 60 && k < 5; n++) begin
      step();
      if ($countones(bus.gnt) > 1) multi_gnt++;
      if (k >= 1 && bus.busy == 1'b0) busy_low++;
      if (bus.ack != '0) begin
        seq[k] = bus.ack;
        k++;
      end
    end
    bus.req = '0;
    check("t2_count",     32'(k), 32'd5);
    check("t2_g0",        32'(seq[0]), 32'h1);
    check("t2_g1",        32'(seq[1]), 32'h2);
    check("t2_g2",        32'(seq[2]), 32'h4);
    check("t2_g3",        32'(seq[3]), 32'h8);
    check("t2_g4",        32'(seq[4]), 32'h1);
    check("t2_onehot",    32'(multi_gnt), 32'd0);
    check("t2_busy_gaps", 32'(busy_low), 32'd4);
    post_idle("t2");

    // T5: reset in WAIT restores rr_ptr and all outputs
    do_reset();
    set_req(1, 32'h300, 32'h9);
    set_req(2, 32'h400, 32'hA);
    bus.cache_out = 32'h66;
    access(4'b0010, 0, 1'b1);
    check("t5_pre_gnt", 32'(gnt_s), 32'h2);
    post_idle("t5_pre");
    bus.req = 4'b0100;
    bus.cache_response = 1'b1;
    step(); step(); step();
    check("t5_mid_busy", 32'(bus.busy), 32'h1);
    check("t5_mid_gnt",  32'(bus.gnt), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_gnt",   32'(bus.gnt), 32'h0);
    check("t5_rst_ack",   32'(bus.ack), 32'h0);
    check("t5_rst_busy",  32'(bus.busy), 32'h0);
    check("t5_rst_err",   32'(bus.err), 32'h0);
    check("t5_rst_caddr", bus.cache_address, 32'h0);
    step();
    rst_n = 1'b1;
    access(4'b0110, 0, 1'b1);
    check("t5_gnt",   32'(gnt_s), 32'h2);
    check("t5_lat",   32'(lat), 32'd3);
    check("t5_rdata", rdata_s, 32'h66);
    post_idle("t5");

    // After reset the mirror holds {0,0}: such a request never reaches the cache
    do_reset();
    set_req(3, 32'h0, 32'h0);
    bus.cache_out = 32'h99;
    access(4'b1000, 1000, 1'b1);
    check("z_lat",   32'(lat), 32'd1);
    check("z_rdata", rdata_s, 32'h0);
    check("z_err",   32'(err_s), 32'h0);
    post_idle("z");
    bus.cache_response = 1'b0;

    // T6: req[2] dropped during WAIT
    bus.cache_out = 32'h3C;
    bus.req = 4'b0100;
    bus.cache_response = 1'b1;
    step(); step(); step();
    bus.req = '0;
    step();
    bus.cache_response = 1'b0;
    pulses = 0; ack_seen = '0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (bus.ack != '0) begin
        pulses++;
        ack_seen = bus.ack;
      end
    end
    check("t6_pulses", 32'(pulses), 32'd1);
    check("t6_ack",    32'(ack_seen), 32'h4);
    check("t6_caddr",  bus.cache_address, 32'h400);
    access(4'b1011, 0, 1'b1);
    check("t6_next_gnt", 32'(gnt_s), 32'h8);
    check("t6_next_lat", 32'(lat), 32'd3);
    post_idle("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
